// File: rtl/general1_pkg.sv
// +----------------------------------------------------------------------------+
// | General1 : shared display types, glyph codes, helpers and FSM state type   |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
`default_nettype none

package General1;

  typedef logic [3:0] uint4_t;
  typedef logic [7:0] uint8_t;

  // Non-decimal nibble codes used as display glyphs
  localparam uint4_t Minus = 4'hA;
  localparam uint4_t Empty = 4'hF;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CONV = 2'd1,
    FMT  = 2'd2
  } seg_state_t;

  function automatic int clog2(input longint unsigned n);
    int r;
    r = 0;
    for (int i = 0; i < 63; i++) begin
      if ((64'd1 << i) < n) r = i + 1;
    end
    return r;
  endfunction

  function automatic longint unsigned pow10(input int n);
    longint unsigned r;
    r = 1;
    for (int i = 0; i < n; i++) r = r * 10;
    return r;
  endfunction

  // Nibble to active-low segment pattern {dp,g,f,e,d,c,b,a}; dp is always off
  function automatic uint8_t BCD2ESC(input uint4_t d);
    case (d)
      4'd0:    return 8'hC0;
      4'd1:    return 8'hF9;
      4'd2:    return 8'hA4;
      4'd3:    return 8'hB0;
      4'd4:    return 8'h99;
      4'd5:    return 8'h92;
      4'd6:    return 8'h82;
      4'd7:    return 8'hF8;
      4'd8:    return 8'h80;
      4'd9:    return 8'h90;
      Minus:   return 8'hBF;
      default: return 8'hFF;
    endcase
  endfunction

endpackage

`default_nettype wire

// File: rtl/seg_scan_display_bin2bcd.sv
// +----------------------------------------------------------------------------+
// | bin2bcd_seq : iterative shift/add-3 binary to BCD, one bit per clock       |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
`default_nettype none

module bin2bcd_seq
  import General1::*;
#(
  parameter int WIDTH  = 13,
  parameter int DIGITS = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start,
  input  logic [WIDTH-1:0]        bin,
  output logic                    done,
  output uint4_t [DIGITS-1:0]     bcd
);

  localparam int CNT_W = clog2(WIDTH + 1);

  logic [WIDTH-1:0]     bin_q, bin_d;
  uint4_t [DIGITS-1:0]  bcd_q, bcd_d;
  uint4_t [DIGITS-1:0]  adj;
  logic [CNT_W-1:0]     cnt_q, cnt_d;

  always_comb begin
    for (int i = 0; i < DIGITS; i++) begin
      adj[i] = (bcd_q[i] >= 4'd5) ? bcd_q[i] + 4'd3 : bcd_q[i];
    end
  end

  always_comb begin
    bin_d = bin_q;
    bcd_d = bcd_q;
    cnt_d = cnt_q;
    if (start) begin
      bin_d = bin;
      bcd_d = '0;
      cnt_d = CNT_W'(WIDTH);
    end else if (cnt_q != '0) begin
      {bcd_d, bin_d} = {adj, bin_q} << 1;
      cnt_d          = cnt_q - CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      bin_q <= '0;
      bcd_q <= '0;
      cnt_q <= '0;
    end else begin
      bin_q <= bin_d;
      bcd_q <= bcd_d;
      cnt_q <= cnt_d;
    end
  end

  // Asserted during the final shift, so bcd is complete on the following cycle
  assign done = (cnt_q == CNT_W'(1));
  assign bcd  = bcd_q;

endmodule

`default_nettype wire

// File: rtl/seg_scan_display.sv
// +----------------------------------------------------------------------------+
// | seg_scan_display : signed value to multiplexed 7-segment display driver    |
// | Build option SEG_LZB_EN enables leading-zero blanking. Rev 1.0             |
// +----------------------------------------------------------------------------+
`default_nettype none

module seg_scan_display
  import General1::*;
#(
  parameter int DIGITS   = 4,
  parameter int WIDTH    = 13,
  parameter int SCAN_DIV = 50000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [WIDTH-1:0]  in_data,
  output logic [7:0]        seg,
  output logic [DIGITS-1:0] an
);

  localparam int CNT_W = (clog2(SCAN_DIV) > 0) ? clog2(SCAN_DIV) : 1;
  localparam int IDX_W = (clog2(DIGITS) > 0) ? clog2(DIGITS) : 1;
  localparam longint unsigned POS_MAX = pow10(DIGITS) - 1;
  localparam longint unsigned NEG_MAX = pow10(DIGITS - 1) - 1;

  seg_state_t           state_q, state_d;
  logic                 neg_q, neg_d;
  logic [WIDTH-1:0]     mag_q, mag_d;
  uint4_t [DIGITS-1:0]  disp_q, disp_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [IDX_W-1:0]     idx_q, idx_d;
  uint8_t               seg_q, seg_d;
  logic [DIGITS-1:0]    an_q, an_d;

  logic                 accept;
  logic                 bcd_done;
  logic [WIDTH-1:0]     in_mag;
  logic                 ovf;
  uint4_t [DIGITS-1:0]  bcd;
  uint4_t [DIGITS-1:0]  fmt;

  // Unsigned magnitude in WIDTH bits holds even the most negative input
  assign in_mag = in_data[WIDTH-1] ? (~in_data) + WIDTH'(1) : in_data;
  assign ovf    = 64'(mag_q) > (neg_q ? NEG_MAX : POS_MAX);

  bin2bcd_seq #(
    .WIDTH  (WIDTH),
    .DIGITS (DIGITS)
  ) u_bin2bcd (
    .clk   (clk),
    .rst   (rst),
    .start (accept),
    .bin   (in_mag),
    .done  (bcd_done),
    .bcd   (bcd)
  );

`ifdef SEG_LZB_EN
  int msd;

  always_comb begin
    msd = 0;
    for (int i = 0; i < DIGITS; i++) begin
      if (bcd[i] != 4'd0) msd = i;
    end
    for (int i = 0; i < DIGITS; i++) begin
      fmt[i] = bcd[i];
      if (i > msd) fmt[i] = Empty;
      if (neg_q && (i == msd + 1)) fmt[i] = Minus;
      if (ovf) fmt[i] = Minus;
    end
  end
`else
  always_comb begin
    for (int i = 0; i < DIGITS; i++) begin
      fmt[i] = bcd[i];
      if (neg_q && (i == DIGITS - 1)) fmt[i] = Minus;
      if (ovf) fmt[i] = Minus;
    end
  end
`endif

  always_comb begin
    state_d  = state_q;
    neg_d    = neg_q;
    mag_d    = mag_q;
    disp_d   = disp_q;
    in_ready = 1'b0;
    accept   = 1'b0;
    case (state_q)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          accept  = 1'b1;
          neg_d   = in_data[WIDTH-1];
          mag_d   = in_mag;
          state_d = CONV;
        end
      end
      CONV: begin
        if (bcd_done) state_d = FMT;
      end
      FMT: begin
        disp_d  = fmt;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Free-running digit scan, unaffected by the conversion handshake
  always_comb begin
    cnt_d = cnt_q + CNT_W'(1);
    idx_d = idx_q;
    if (cnt_q == CNT_W'(SCAN_DIV - 1)) begin
      cnt_d = '0;
      idx_d = (idx_q == IDX_W'(DIGITS - 1)) ? '0 : idx_q + IDX_W'(1);
    end
    an_d  = ~(DIGITS'(1) << idx_q);
    seg_d = BCD2ESC(disp_q[idx_q]);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      neg_q   <= 1'b0;
      mag_q   <= '0;
      disp_q  <= {DIGITS{Empty}};
      cnt_q   <= '0;
      idx_q   <= '0;
      seg_q   <= 8'hFF;
      an_q    <= '1;
    end else begin
      state_q <= state_d;
      neg_q   <= neg_d;
      mag_q   <= mag_d;
      disp_q  <= disp_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      seg_q   <= seg_d;
      an_q    <= an_d;
    end
  end

  assign seg = seg_q;
  assign an  = an_q;

endmodule

`default_nettype wire

// File: tb/tb_seg_scan_display.sv
// +----------------------------------------------------------------------------+
// | tb_seg_scan_display : directed table-driven bench for seg_scan_display     |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
`default_nettype none

module tb_seg_scan_display;

  localparam int DIGITS   = 4;
  localparam int WIDTH    = 13;
  localparam int SCAN_DIV = 4;
  localparam int NVEC     = 11;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              in_valid = 1'b0;
  logic              in_ready;
  logic [WIDTH-1:0]  in_data = '0;
  logic [7:0]        seg;
  logic [DIGITS-1:0] an;

  int n_pass  = 0;
  int n_total = 0;

  // exp packs the four expected seg bytes as {digit3, digit2, digit1, digit0}
  typedef struct packed {
    logic [WIDTH-1:0] val;
    logic [31:0]      exp;
  } vec_t;

  vec_t vecs [NVEC];

  seg_scan_display #(
    .DIGITS   (DIGITS),
    .WIDTH    (WIDTH),
    .SCAN_DIV (SCAN_DIV)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_data  (in_data),
    .seg      (seg),
    .an       (an)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", nm, act, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_digit(input int i, input logic [7:0] exp, input string nm);
    logic [DIGITS-1:0] want;
    int n;
    want = ~(DIGITS'(1) << i);
    n = 0;
    while (an !== want && n < 64) begin
      tick();
      n++;
    end
    if (an !== want) chk({nm, " scan timeout"}, {28'd0, an}, {28'd0, want});
    else chk(nm, {24'd0, seg}, {24'd0, exp});
  endtask

  task automatic check_display(input logic [31:0] exp, input string nm);
    for (int i = 0; i < DIGITS; i++) begin
      check_digit(i, exp[i*8 +: 8], $sformatf("%s d%0d", nm, i));
    end
  endtask

  task automatic wait_ready(input string nm);
    int n;
    n = 0;
    while (in_ready !== 1'b1 && n < 64) begin
      tick();
      n++;
    end
    if (in_ready !== 1'b1) chk({nm, " ready timeout"}, {31'd0, in_ready}, 32'd1);
  endtask

  task automatic send(input logic [WIDTH-1:0] v);
    in_data  = v;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
  endtask

  task automatic set_vec(input int k, input int v, input logic [31:0] plain, input logic [31:0] lzb);
    vecs[k].val = WIDTH'(v);
`ifdef SEG_LZB_EN
    vecs[k].exp = lzb;
`else
    vecs[k].exp = plain;
`endif
  endtask

  initial begin
    set_vec(0,  1234,  32'hF9A4B099, 32'hF9A4B099);
    set_vec(1,  -42,   32'hBFC099A4, 32'hFFBF99A4);
    set_vec(2,  0,     32'hC0C0C0C0, 32'hFFFFFFC0);
    set_vec(3,  -1000, 32'hBFBFBFBF, 32'hBFBFBFBF);
    set_vec(4,  -999,  32'hBF909090, 32'hBF909090);
    set_vec(5,  4095,  32'h99C09092, 32'h99C09092);
    set_vec(6,  -4096, 32'hBFBFBFBF, 32'hBFBFBFBF);
    set_vec(7,  7,     32'hC0C0C0F8, 32'hFFFFFFF8);
    set_vec(8,  -5,    32'hBFC0C092, 32'hFFFFBF92);
    set_vec(9,  999,   32'hC0909090, 32'hFF909090);
    set_vec(10, 1000,  32'hF9C0C0C0, 32'hF9C0C0C0);

    // Reset state and free-running scan
    rst = 1'b1;
    tick();
    tick();
    chk("rst seg", {24'd0, seg}, 32'hFF);
    chk("rst an", {28'd0, an}, 32'hF);
    chk("rst in_ready", {31'd0, in_ready}, 32'd1);
    rst = 1'b0;
    for (int k = 0; k < 16; k++) begin
      tick();
      chk($sformatf("scan an k%0d", k), {28'd0, an}, {28'd0, ~(4'd1 << (k / 4))});
      chk($sformatf("scan seg k%0d", k), {24'd0, seg}, 32'hFF);
    end

    // Handshake latency: busy for T+1..T+14, ready and updated at T+15
    wait_ready("lat");
    send(WIDTH'(1234));
    for (int k = 0; k < 14; k++) begin
      chk($sformatf("busy T+%0d", k + 1), {31'd0, in_ready}, 32'd0);
      tick();
    end
    chk("ready T+15", {31'd0, in_ready}, 32'd1);
    check_display(32'hF9A4B099, "lat 1234");

    for (int k = 0; k < NVEC; k++) begin
      wait_ready($sformatf("vec%0d", k));
      send(vecs[k].val);
      tick();
      tick();
      wait_ready($sformatf("vec%0d done", k));
      check_display(vecs[k].exp, $sformatf("vec%0d %0d", k, $signed(vecs[k].val)));
    end

    // A second in_valid during CONV is dropped, not queued
    wait_ready("ign");
    send(WIDTH'(321));
    tick();
    tick();
    in_data  = WIDTH'(55);
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    wait_ready("ign done");
    tick();
    chk("ign no requeue", {31'd0, in_ready}, 32'd1);
`ifdef SEG_LZB_EN
    check_display(32'hFFB0A4F9, "ign 321");
`else
    check_display(32'hC0B0A4F9, "ign 321");
`endif

    // Reset at T+5 of a conversion aborts it and blanks the display
    wait_ready("abort");
    send(WIDTH'(1234));
    repeat (4) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("abort in_ready", {31'd0, in_ready}, 32'd1);
    check_display(32'hFFFFFFFF, "abort");
    repeat (20) tick();
    chk("abort idle", {31'd0, in_ready}, 32'd1);
    check_display(32'hFFFFFFFF, "abort late");

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

`default_nettype wire
